path_replay_stack: RTL

- Location stack on the solver's push/pop/topLoc interface; holds the current path of 8-bit grid locations (row = [7:4], col = [3:0], destination 8'hFF).
- When the solver pulses done, the block reads the stored path back bottom-to-top (start to destination) and streams it out one location per valid/ready handshake.
- It is the reader side of the path the solver writes.

---
 rtl/path_replay_stack.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/path_replay_stack.sv
// Location stack for the maze solver's current path.
// The solver pushes and pops locations while it searches. When it pulses done,
// the stored path is streamed out from bottom (start) to top (destination)
// over a valid/ready handshake.
module path_replay_stack #(
    parameter int unsigned LOC_W = 8,
    parameter int unsigned DEPTH = 256,
    parameter int unsigned CNT_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [LOC_W-1:0] i_push_loc,
    input  logic             i_done,
    input  logic             i_fail,
    output logic [LOC_W-1:0] o_top_loc,
    output logic             o_emp_stck,
    output logic             o_full,
    output logic             o_overflow,
    output logic             o_underflow,
    output logic             o_busy,
    output logic [LOC_W-1:0] o_path_loc,
    output logic             o_path_valid,
    input  logic             i_path_ready,
    output logic             o_path_last,
    output logic             o_replay_done
);

    localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StReplay, StFinish} state_e;

    state_e           r_state;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_rd_ptr;
    logic             r_overflow;
    logic             r_underflow;
    logic [LOC_W-1:0] r_mem [DEPTH];

    logic              w_empty;
    logic              w_full;
    logic [CNT_W-1:0]  w_cnt_m1;
    logic [ADDR_W-1:0] w_top_idx;
    logic [ADDR_W-1:0] w_rd_idx;
    logic              w_stack_cmd;
    logic              w_last;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_wr_idx;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_cnt_m1  = r_count - CNT_W'(1);
    assign w_top_idx = w_cnt_m1[ADDR_W-1:0];
    assign w_rd_idx  = r_rd_ptr[ADDR_W-1:0];
    assign w_last    = (r_rd_ptr == w_cnt_m1);

    // Push/pop only act in IDLE and only when neither fail nor done wins priority.
    assign w_stack_cmd = (r_state == StIdle) && !i_fail && !i_done;

    // Write port decode: push&pop on a non-empty stack replaces the top entry,
    // otherwise a push lands at the next free slot unless the stack is full.
    always_comb begin
        w_wr_en  = 1'b0;
        w_wr_idx = '0;
        if (w_stack_cmd && i_push) begin
            if (i_pop && !w_empty) begin
                w_wr_en  = 1'b1;
                w_wr_idx = w_top_idx;
            end else if (!w_full) begin
                w_wr_en  = 1'b1;
                w_wr_idx = r_count[ADDR_W-1:0];
            end
        end
    end

    // Storage array; no reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_idx] <= i_push_loc;
        end
    end

    // Control FSM: occupancy, read pointer and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_count     <= '0;
            r_rd_ptr    <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_fail) begin
                        r_count <= '0;
                    end else if (i_done) begin
                        r_rd_ptr <= '0;
                        r_state  <= w_empty ? StFinish : StReplay;
                    end else if (i_push && i_pop) begin
                        // Non-empty: top replaced in place, count unchanged.
                        if (w_empty) begin
                            r_count <= CNT_W'(1);
                        end
                    end else if (i_push) begin
                        if (w_full) begin
                            r_overflow <= 1'b1;
                        end else begin
                            r_count <= r_count + CNT_W'(1);
                        end
                    end else if (i_pop) begin
                        if (w_empty) begin
                            r_underflow <= 1'b1;
                        end else begin
                            r_count <= w_cnt_m1;
                        end
                    end
                end
                StReplay: begin
                    if (i_path_ready) begin
                        if (w_last) begin
                            r_state <= StFinish;
                        end else begin
                            r_rd_ptr <= r_rd_ptr + CNT_W'(1);
                        end
                    end
                end
                StFinish: begin
                    r_count  <= '0;
                    r_rd_ptr <= '0;
                    r_state  <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // Outputs decode directly from registered state, so reset clears them at once.
    assign o_top_loc     = w_empty ? '0 : r_mem[w_top_idx];
    assign o_emp_stck    = w_empty;
    assign o_full        = w_full;
    assign o_overflow    = r_overflow;
    assign o_underflow   = r_underflow;
    assign o_busy        = (r_state != StIdle);
    assign o_path_valid  = (r_state == StReplay);
    assign o_path_loc    = o_path_valid ? r_mem[w_rd_idx] : '0;
    assign o_path_last   = o_path_valid && w_last;
    assign o_replay_done = (r_state == StFinish);

endmodule
